// File: rtl/cfg_wb_arbiter.sv
// rtl/cfg_wb_arbiter.sv - round-robin Wishbone classic arbiter with bus timeout
// Shares one config-register slave between NM masters; grant held while owner keeps CYC.
module cfg_wb_arbiter #(
  parameter int DWIDTH  = 32,
  parameter int NM      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NM-1:0]            m_cyc_i,
  input  logic [NM-1:0]            m_stb_i,
  input  logic [NM-1:0]            m_we_i,
  input  logic [NM*DWIDTH/8-1:0]   m_sel_i,
  input  logic [NM*DWIDTH-1:0]     m_adr_i,
  input  logic [NM*DWIDTH-1:0]     m_dat_i,
  output logic [NM-1:0]            m_ack_o,
  output logic [NM-1:0]            m_err_o,
  output logic [DWIDTH-1:0]        m_dat_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [DWIDTH/8-1:0]      s_sel_o,
  output logic [DWIDTH-1:0]        s_adr_o,
  output logic [DWIDTH-1:0]        s_dat_o,
  input  logic                     s_ack_i,
  input  logic [DWIDTH-1:0]        s_dat_i,
  output logic [NM-1:0]            grant_o
);

  localparam int SW = DWIDTH / 8;
  localparam int LW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [NM-1:0] grant_q, grant_nxt;
  logic [LW-1:0] last_q, last_nxt;
  logic [LW-1:0] g_idx, pick_idx;
  logic [15:0]   tmo_cnt, tmo_nxt;
  logic [NM-1:0] req;
  logic          pick_vld;
  logic          busy, raw_stb, tmo_fire, ack;

  assign req     = m_cyc_i & m_stb_i;
  assign grant_o = grant_q;
  assign busy    = (state == BUSY);

  always_comb begin
    g_idx = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant_q[k]) g_idx = LW'(k);
    end
  end

  // Search starts just after the previous owner, so every requester is reached within NM rounds.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 1; i <= NM; i++) begin
      if (!pick_vld && req[(int'(last_q) + i) % NM]) begin
        pick_vld = 1'b1;
        pick_idx = LW'((int'(last_q) + i) % NM);
      end
    end
  end

  // A same-cycle ACK beats the timeout, so the fire term looks at the raw slave ACK.
  assign raw_stb  = busy & m_cyc_i[g_idx] & m_stb_i[g_idx];
  assign tmo_fire = raw_stb & ~s_ack_i & (tmo_cnt == 16'(TIMEOUT - 1));
  assign s_cyc_o  = busy & m_cyc_i[g_idx] & ~tmo_fire;
  assign s_stb_o  = raw_stb & ~tmo_fire;
  assign ack      = s_ack_i & s_stb_o;

  assign s_we_o  = busy & m_we_i[g_idx];
  assign s_sel_o = busy ? m_sel_i[int'(g_idx)*SW +: SW] : '0;
  assign s_adr_o = busy ? m_adr_i[int'(g_idx)*DWIDTH +: DWIDTH] : '0;
  assign s_dat_o = busy ? m_dat_i[int'(g_idx)*DWIDTH +: DWIDTH] : '0;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = ack ? grant_q : '0;
  assign m_err_o = tmo_fire ? grant_q : '0;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    tmo_nxt   = tmo_cnt;
    case (state)
      IDLE: begin
        tmo_nxt = '0;
        if (pick_vld) begin
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          state_nxt           = BUSY;
        end
      end
      BUSY: begin
        if (!m_cyc_i[g_idx] || tmo_fire) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = g_idx;
          tmo_nxt   = '0;
        end else if (ack || !s_stb_o) begin
          tmo_nxt = '0;
        end else begin
          tmo_nxt = tmo_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NM - 1);
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_cfg_wb_arbiter.sv
// tb/tb_cfg_wb_arbiter.sv - directed and random bench for cfg_wb_arbiter
// Slave stub with programmable ACK latency; masters driven after each rising edge.
module tb_cfg_wb_arbiter;

  localparam int DW  = 32;
  localparam int NM  = 4;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    m_cyc, m_stb, m_we, m_ack, m_err, grant;
  logic [NM*SW-1:0] m_sel;
  logic [NM*DW-1:0] m_adr, m_dat;
  logic [DW-1:0]    m_dat_o, s_adr, s_dat, s_dat_i;
  logic [SW-1:0]    s_sel;
  logic             s_cyc, s_stb, s_we, s_ack_i;

  always #5 clk = ~clk;

  cfg_wb_arbiter #(.DWIDTH(DW), .NM(NM), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant)
  );

  logic [DW-1:0] mem [16];
  logic [DW-1:0] model [16];
  assign s_dat_i = mem[s_adr[3:0]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [NM-1:0] smp_grant, smp_ack, smp_err;
  logic          smp_scyc, smp_sstb, smp_swe;
  logic [DW-1:0] smp_sadr, smp_sdat, smp_mdat;
  logic [SW-1:0] smp_ssel;
  int            ack_cnt [NM];
  bit            slave_noack = 1'b0;
  bit            slave_rand  = 1'b0;
  int            slave_lat   = 0;
  int            cur_lat     = 0;
  int            wcnt        = 0;

  // Observe the cycle at the falling edge, then let the slave stub react after the rising edge.
  task automatic tick();
    @(negedge clk);
    smp_grant = grant;  smp_ack = m_ack;  smp_err = m_err;
    smp_scyc  = s_cyc;  smp_sstb = s_stb; smp_swe = s_we;
    smp_sadr  = s_adr;  smp_sdat = s_dat; smp_ssel = s_sel; smp_mdat = m_dat_o;
    for (int k = 0; k < NM; k++) ack_cnt[k] += int'(smp_ack[k]);
    @(posedge clk);
    #1;
    if (s_ack_i && smp_sstb) begin
      if (smp_swe)
        for (int b = 0; b < SW; b++)
          if (smp_ssel[b]) mem[smp_sadr[3:0]][b*8 +: 8] = smp_sdat[b*8 +: 8];
      s_ack_i = 1'b0;
      wcnt    = 0;
    end else if (s_ack_i) begin
      s_ack_i = 1'b0;
    end else if (smp_sstb && !slave_noack) begin
      if (wcnt >= cur_lat) begin
        s_ack_i = 1'b1;
        wcnt    = 0;
        cur_lat = slave_rand ? int'($urandom_range(0, 3)) : slave_lat;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [DW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_we[k]  = we;
    m_adr[k*DW +: DW] = adr;
    m_dat[k*DW +: DW] = dat;
    m_sel[k*SW +: SW] = sel;
  endtask

  task automatic drop(input int k);
    set_m(k, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_ack(input int k, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!smp_ack[k] && smp_err == '0 && n < 30);
    check(tag, 64'(smp_ack[k]), 64'd1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    s_ack_i = 1'b0;
    wcnt    = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < NM; k++) ack_cnt[k] = 0;
  endtask

  task automatic new_op(input int k);
    set_m(k, 1'b1, 1'b1, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 15)),
          DW'($urandom), SW'($urandom_range(1, 15)));
  endtask

  int ord [5] = '{0, 1, 2, 3, 0};
  int idle_n, nt, busy_n;
  int rem [NM];
  int done_n [NM];
  bit act [NM];
  logic [3:0] a;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // reset state and single write/readback from master 0
    reset_dut();
    tick();
    check("rst_grant", 64'(smp_grant), 64'd0);
    check("rst_scyc", 64'(smp_scyc), 64'd0);
    check("rst_sstb", 64'(smp_sstb), 64'd0);
    check("rst_swe", 64'(smp_swe), 64'd0);
    check("rst_ack", 64'(smp_ack), 64'd0);
    check("rst_err", 64'(smp_err), 64'd0);
    check("rst_sadr", 64'(smp_sadr), 64'd0);
    set_m(0, 1'b1, 1'b1, 1'b1, 32'd2, 32'hDEADBEEF, 4'hF);
    tick();
    check("t1_arb_cycle", 64'(smp_grant), 64'd0);
    tick();
    check("t1_grant", 64'(smp_grant), 64'b0001);
    check("t1_sadr", 64'(smp_sadr), 64'd2);
    check("t1_sdat", 64'(smp_sdat), 64'hDEADBEEF);
    check("t1_sstb", 64'(smp_sstb), 64'd1);
    tick();
    check("t1_wr_ack", 64'(smp_ack), 64'b0001);
    drop(0);
    tick();
    check("t1_hold_grant", 64'(smp_grant), 64'b0001);
    check("t1_scyc_drop", 64'(smp_scyc), 64'd0);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'd2, 32'd0, 4'hF);
    wait_ack(0, "t1_rd_ack");
    check("t1_rd_dat", 64'(smp_mdat), 64'hDEADBEEF);
    drop(0);
    tick();

    // all four request together; m0 asks again after its first turn
    reset_dut();
    for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b1, 1'b1, DW'(4 + k), DW'(32'h100 + k), 4'hF);
    for (int n = 0; n < 5; n++) begin
      idle_n = 0;
      nt     = 0;
      do begin
        tick();
        if (smp_grant == '0) idle_n++;
        nt++;
      end while (smp_grant == '0 && nt < 10);
      check("t2_grant_order", 64'(smp_grant), 64'(1) << ord[n]);
      if (n > 0) check("t2_idle_gap", 64'(idle_n), 64'd1);
      wait_ack(ord[n], "t2_ack");
      drop(ord[n]);
      tick();
      if (n == 0) set_m(0, 1'b1, 1'b1, 1'b1, 32'd9, 32'h55, 4'hF);
    end
    check("t2_acks_m0", 64'(ack_cnt[0]), 64'd2);
    for (int k = 1; k < NM; k++) check("t2_acks_mk", 64'(ack_cnt[k]), 64'd1);

    // m1 holds the bus for three back-to-back writes while m2 waits
    reset_dut();
    set_m(1, 1'b1, 1'b1, 1'b1, 32'd8, 32'hA0, 4'hF);
    set_m(2, 1'b1, 1'b1, 1'b1, 32'd12, 32'hB0, 4'hF);
    tick();
    tick();
    check("t3_grant_m1", 64'(smp_grant), 64'b0010);
    for (int i = 0; i < 3; i++) begin
      wait_ack(1, "t3_m1_ack");
      if (i < 2) set_m(1, 1'b1, 1'b1, 1'b1, DW'(9 + i), DW'(32'hA1 + i), 4'hF);
      else drop(1);
    end
    check("t3_m1_acks", 64'(ack_cnt[1]), 64'd3);
    check("t3_m2_not_early", 64'(ack_cnt[2]), 64'd0);
    tick();
    check("t3_release_cycle", 64'(smp_grant), 64'b0010);
    tick();
    check("t3_idle", 64'(smp_grant), 64'd0);
    tick();
    check("t3_grant_m2", 64'(smp_grant), 64'b0100);
    wait_ack(2, "t3_m2_ack");
    drop(2);
    tick();
    check("t3_mem10", 64'(mem[10]), 64'hA2);
    check("t3_mem12", 64'(mem[12]), 64'hB0);

    // dead slave: timeout error, then normal service resumes
    reset_dut();
    slave_noack = 1'b1;
    set_m(3, 1'b1, 1'b1, 1'b1, 32'd3, 32'hCC, 4'hF);
    busy_n = 0;
    nt     = 0;
    do begin
      tick();
      if (smp_grant != '0) busy_n++;
      nt++;
    end while (smp_err == '0 && nt < 40);
    check("t4_err", 64'(smp_err), 64'b1000);
    check("t4_busy_cycles", 64'(busy_n), 64'd8);
    check("t4_scyc_low", 64'(smp_scyc), 64'd0);
    check("t4_sstb_low", 64'(smp_sstb), 64'd0);
    drop(3);
    tick();
    check("t4_back_idle", 64'(smp_grant), 64'd0);
    check("t4_err_one_pulse", 64'(smp_err), 64'd0);
    slave_noack = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'd2, 32'd0, 4'hF);
    wait_ack(0, "t4_recover_ack");
    drop(0);
    tick();

    // reset in the middle of an m2 transfer
    reset_dut();
    slave_lat = 3;
    cur_lat   = 3;
    set_m(2, 1'b1, 1'b1, 1'b1, 32'd5, 32'hEE, 4'hF);
    tick();
    tick();
    check("t5_grant_m2", 64'(smp_grant), 64'b0100);
    rst = 1'b1;
    tick();
    check("t5_no_ack_in_rst", 64'(smp_ack), 64'd0);
    rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b1, 32'd6, 32'hFF, 4'hF);
    tick();
    check("t5_grant_cleared", 64'(smp_grant), 64'd0);
    check("t5_scyc_cleared", 64'(smp_scyc), 64'd0);
    check("t5_ack_cleared", 64'(smp_ack), 64'd0);
    tick();
    check("t5_m0_priority", 64'(smp_grant), 64'b0001);
    wait_ack(0, "t5_m0_ack");
    drop(0);
    tick();
    wait_ack(2, "t5_m2_later_ack");
    check("t5_m2_acks", 64'(ack_cnt[2]), 64'd1);
    drop(2);
    tick();
    slave_lat = 0;

    // random traffic with scoreboard of the register bank
    reset_dut();
    slave_rand = 1'b1;
    cur_lat    = int'($urandom_range(0, 3));
    for (int i = 0; i < 16; i++) begin
      mem[i]   = '0;
      model[i] = '0;
    end
    for (int k = 0; k < NM; k++) begin
      rem[k]    = 0;
      done_n[k] = 0;
      act[k]    = 1'b0;
    end
    for (int c = 0; c < 10000; c++) begin
      tick();
      check("t6_grant_onehot", 64'($onehot0(smp_grant)), 64'd1);
      check("t6_ack_onehot", 64'($onehot0(smp_ack)), 64'd1);
      check("t6_ack_in_grant", 64'(smp_ack & ~smp_grant), 64'd0);
      check("t6_no_err", 64'(smp_err), 64'd0);
      for (int k = 0; k < NM; k++) begin
        if (act[k] && smp_ack[k]) begin
          a = m_adr[k*DW +: 4];
          if (m_we[k]) begin
            for (int b = 0; b < SW; b++)
              if (m_sel[k*SW + b]) model[a][b*8 +: 8] = m_dat[k*DW + b*8 +: 8];
          end else begin
            check("t6_rd_dat", 64'(smp_mdat), 64'(model[a]));
          end
          done_n[k]++;
          rem[k]--;
          if (rem[k] == 0) begin
            drop(k);
            act[k] = 1'b0;
          end else begin
            new_op(k);
          end
        end else if (!act[k] && $urandom_range(0, 3) == 0) begin
          rem[k] = int'($urandom_range(1, 3));
          act[k] = 1'b1;
          new_op(k);
        end
      end
    end
    for (int k = 0; k < NM; k++) begin
      drop(k);
      check("t6_progress", 64'(done_n[k] > 0), 64'd1);
    end
    tick();
    tick();
    for (int i = 0; i < 16; i++) check("t6_bank", 64'(mem[i]), 64'(model[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
